// File: rtl/seg_mux_driver.sv
// Two-digit multiplexed 7-segment driver: sequential double-dabble BCD conversion plus a refresh scan.
// Define SEG_DEADTIME_EN to add a dark gap of DEADTIME cycles at every digit-slot switch.
module seg_mux_driver #(
  parameter int unsigned REFRESH_DIV = 1024,
  parameter int unsigned DEADTIME    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] value,
  input  logic       value_valid,
  input  logic       blank,
  input  logic       seg_pol,
  input  logic       com_pol,
  output logic [7:0] seg,
  output logic [1:0] com,
  output logic [1:0] com_oe,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, CONVERT, COMMIT} state_t;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_EMPTY = 4'hF;
  localparam int unsigned CW = $clog2(REFRESH_DIV);

  state_t      state;
  logic [6:0]  bin;
  logic [7:0]  bcd;
  logic [2:0]  step;
  logic        is_hundred;
  logic        is_dash;
  logic        is_small;
  logic [3:0]  ones_dig;
  logic [3:0]  tens_dig;
  logic [CW-1:0] refresh_cnt;
  logic        slot;
  logic        wrap;
  logic        dark_gap;
  logic [3:0]  cur_dig;
  logic        lit;
  logic [7:0]  pattern;
  logic [7:0]  seg_next;
  logic [1:0]  com_next;

  // One double-dabble step: add 3 to any nibble >= 5, then shift in the next binary bit.
  function automatic logic [7:0] dabble(input logic [7:0] b, input logic in_bit);
    logic [7:0] a;
    a = b;
    if (a[3:0] >= 4'd5) a[3:0] = a[3:0] + 4'd3;
    if (a[7:4] >= 4'd5) a[7:4] = a[7:4] + 4'd3;
    return {a[6:0], in_bit};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      step       <= '0;
      is_hundred <= 1'b0;
      is_dash    <= 1'b0;
      is_small   <= 1'b0;
      ones_dig   <= DIG_EMPTY;
      tens_dig   <= DIG_EMPTY;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid) begin
            bin        <= value;
            bcd        <= '0;
            is_hundred <= (value == 7'd100);
            is_dash    <= (value > 7'd100);
            is_small   <= (value < 7'd10);
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          bcd   <= dabble(bcd, bin[6]);
          bin   <= {bin[5:0], 1'b0};
          step  <= 3'd1;
          state <= CONVERT;
        end
        CONVERT: begin
          bcd  <= dabble(bcd, bin[6]);
          bin  <= {bin[5:0], 1'b0};
          step <= step + 3'd1;
          if (step == 3'd6) state <= COMMIT;
        end
        COMMIT: begin
          if (is_dash) begin
            ones_dig <= DIG_DASH;
            tens_dig <= DIG_DASH;
          end else if (is_hundred) begin
            ones_dig <= 4'd0;
            tens_dig <= 4'd0;
          end else begin
            ones_dig <= bcd[3:0];
            tens_dig <= is_small ? DIG_EMPTY : bcd[7:4];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wrap = (refresh_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      slot        <= 1'b0;
    end else if (wrap) begin
      refresh_cnt <= '0;
      slot        <= ~slot;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

`ifdef SEG_DEADTIME_EN
  localparam int unsigned DW = $clog2(DEADTIME + 1);
  logic [DW-1:0] dead_cnt;

  // The gap is carved out of the start of each slot, so the slot period stays REFRESH_DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 dead_cnt <= '0;
    else if (wrap)           dead_cnt <= DW'(DEADTIME);
    else if (dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
  end

  assign dark_gap = (dead_cnt != '0);
`else
  assign dark_gap = 1'b0;

  if (DEADTIME > REFRESH_DIV) begin : g_deadtime_unused
  end
`endif

  assign cur_dig = slot ? tens_dig : ones_dig;
  assign lit     = !blank && (cur_dig != DIG_EMPTY) && !dark_gap;

  always_comb begin
    pattern = 8'h00;
    case (cur_dig)
      4'd0:     pattern = 8'h3F;
      4'd1:     pattern = 8'h06;
      4'd2:     pattern = 8'h5B;
      4'd3:     pattern = 8'h4F;
      4'd4:     pattern = 8'h66;
      4'd5:     pattern = 8'h6D;
      4'd6:     pattern = 8'h7D;
      4'd7:     pattern = 8'h07;
      4'd8:     pattern = 8'h7F;
      4'd9:     pattern = 8'h6F;
      DIG_DASH: pattern = 8'h40;
      default:  pattern = 8'h00;
    endcase
  end

  always_comb begin
    seg_next = seg_pol ? 8'h00 : 8'hFF;
    com_next = {2{~com_pol}};
    if (lit) begin
      seg_next       = seg_pol ? pattern : ~pattern;
      com_next[slot] = com_pol;
    end
  end

  // Registered outputs keep polarity or blank changes glitch-free between edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= 8'h00;
      com    <= 2'b00;
      com_oe <= 2'b00;
    end else begin
      seg    <= seg_next;
      com    <= com_next;
      com_oe <= 2'b11;
    end
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed self-checking bench for seg_mux_driver with a short refresh period.
module tb_seg_mux_driver;

  localparam int R = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] value;
  logic       value_valid;
  logic       blank;
  logic       seg_pol;
  logic       com_pol;
  logic [7:0] seg;
  logic [1:0] com;
  logic [1:0] com_oe;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc;

  seg_mux_driver #(.REFRESH_DIV(R), .DEADTIME(4)) dut (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
    .blank(blank), .seg_pol(seg_pol), .com_pol(com_pol),
    .seg(seg), .com(com), .com_oe(com_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the refresh scan position follows from this alone.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe a value in and count the cycles busy stays high.
  task automatic apply_stimulus(input logic [6:0] v, output int busy_cycles);
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Advance to the middle of the given displayed slot (0 = ones, 1 = tens).
  task automatic wait_slot(input int s, input string tag);
    bit found = 0;
    for (int i = 0; i < 4 * R && !found; i++) begin
      @(negedge clk);
      if (cyc >= 1 && ((cyc - 1) / R) % 2 == s && (cyc - 1) % R == R / 2) found = 1;
    end
    check_output({tag, "_sync"}, {7'd0, found}, 8'd1);
  endtask

  task automatic check_display(input string tag, input logic [1:0] c0, input logic [7:0] s0,
                               input logic [1:0] c1, input logic [7:0] s1);
    wait_slot(0, tag);
    check_output({tag, "_ones_com"}, {6'd0, com}, {6'd0, c0});
    check_output({tag, "_ones_seg"}, seg, s0);
    wait_slot(1, tag);
    check_output({tag, "_tens_com"}, {6'd0, com}, {6'd0, c1});
    check_output({tag, "_tens_seg"}, seg, s1);
  endtask

  logic [6:0] vec_val  [9] = '{7'd42, 7'd7, 7'd100, 7'd120, 7'd0, 7'd58, 7'd99, 7'd10, 7'd101};
  logic [7:0] vec_ones [9] = '{8'h5B, 8'h07, 8'h3F, 8'h40, 8'h3F, 8'h7F, 8'h6F, 8'h3F, 8'h40};
  logic [1:0] vec_tcom [9] = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [7:0] vec_tens [9] = '{8'h66, 8'h00, 8'h3F, 8'h40, 8'h00, 8'h6D, 8'h6F, 8'h06, 8'h40};

  initial begin
    int n;
    int run_len;
    int exp_len;

    rst         = 1'b1;
    value       = '0;
    value_valid = 1'b0;
    blank       = 1'b0;
    seg_pol     = 1'b1;
    com_pol     = 1'b0;

    #1;
    check_output("por_seg", seg, 8'h00);
    check_output("por_com", {6'd0, com}, 8'h00);
    check_output("por_com_oe", {6'd0, com_oe}, 8'h00);
    check_output("por_busy", {7'd0, busy}, 8'h00);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("rel_com_oe", {6'd0, com_oe}, 8'h03);
    check_output("rel_com", {6'd0, com}, 8'h03);
    check_output("rel_seg", seg, 8'h00);
    check_display("empty", 2'b11, 8'h00, 2'b11, 8'h00);

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vec_val[i], n);
      check_output($sformatf("busy_len_%0d", vec_val[i]), 8'(n), 8'd8);
      check_display($sformatf("val_%0d", vec_val[i]), 2'b10, vec_ones[i], vec_tcom[i], vec_tens[i]);
    end

    // Slot length, measured as the run of ones-slot common pattern.
    apply_stimulus(7'd42, n);
    n = 0;
    while (com === 2'b10 && n < 4 * R) begin n++; @(negedge clk); end
    n = 0;
    while (com !== 2'b10 && n < 4 * R) begin n++; @(negedge clk); end
    run_len = 0;
    while (com === 2'b10 && run_len < 4 * R) begin run_len++; @(negedge clk); end
`ifdef SEG_DEADTIME_EN
    exp_len = R - 4;
`else
    exp_len = R;
`endif
    check_output("slot_len", 8'(run_len), 8'(exp_len));

    wait_slot(0, "pol");
    seg_pol = 1'b0;
    com_pol = 1'b1;
    @(negedge clk);
    check_output("pol_ones_com", {6'd0, com}, 8'h01);
    check_output("pol_ones_seg", seg, 8'hA4);
    wait_slot(1, "pol");
    check_output("pol_tens_com", {6'd0, com}, 8'h02);
    check_output("pol_tens_seg", seg, 8'h99);
    blank = 1'b1;
    @(negedge clk);
    check_output("blank_com", {6'd0, com}, 8'h00);
    check_output("blank_seg", seg, 8'hFF);
    blank   = 1'b0;
    seg_pol = 1'b1;
    com_pol = 1'b0;

    // A strobe while busy must be dropped, not queued.
    apply_stimulus(7'd120, n);
    @(negedge clk);
    value       = 7'd42;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    @(negedge clk);
    value       = 7'd13;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    check_output("ignore_busy_done", {7'd0, busy}, 8'h00);
    repeat (3) @(negedge clk);
    check_output("ignore_no_requeue", {7'd0, busy}, 8'h00);
    check_display("ignore", 2'b10, 8'h5B, 2'b01, 8'h66);

    // Reset in the middle of a conversion and in the middle of a clock period.
    @(negedge clk);
    value       = 7'd99;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_rst_seg", seg, 8'h00);
    check_output("mid_rst_com", {6'd0, com}, 8'h00);
    check_output("mid_rst_com_oe", {6'd0, com_oe}, 8'h00);
    check_output("mid_rst_busy", {7'd0, busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rel_com_oe", {6'd0, com_oe}, 8'h03);
    check_output("mid_rel_busy", {7'd0, busy}, 8'h00);
    check_display("after_rst", 2'b11, 8'h00, 2'b11, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
